// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - writeback arbiter bus: ALU/LSU writeback, load issue, RF write port, hazard query
interface rf_wb_arbiter_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          alu_wb_valid;
    logic [3:0]    alu_wb_rd;
    logic [63:0]   alu_wb_data;
    logic          alu_stall;

    logic          lsu_issue_valid;
    logic [3:0]    lsu_issue_rd;
    logic          lsu_wb_valid;
    logic [3:0]    lsu_wb_rd;
    logic [63:0]   lsu_wb_data;
    logic          lsu_wb_ready;

    logic          rf_we;
    logic [3:0]    rf_rd_addr;
    logic [63:0]   rf_rd_data;

    logic [3:0]    hz_rs1_addr;
    logic [3:0]    hz_rs2_addr;
    logic [3:0]    hz_rd_addr;
    logic          hz_busy;

    logic [CW-1:0] fifo_count;

    modport master (
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output lsu_issue_valid, lsu_issue_rd,
        output lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
        output hz_rs1_addr, hz_rs2_addr, hz_rd_addr,
        input  alu_stall, lsu_wb_ready, rf_we, rf_rd_addr, rf_rd_data,
        input  hz_busy, fifo_count
    );

    modport slave (
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  lsu_issue_valid, lsu_issue_rd,
        input  lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
        input  hz_rs1_addr, hz_rs2_addr, hz_rd_addr,
        output alu_stall, lsu_wb_ready, rf_we, rf_rd_addr, rf_rd_data,
        output hz_busy, fifo_count
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - shares the RF write port between ALU writeback and buffered LSU returns
module rf_wb_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    rf_wb_arbiter_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] SLIM     = SW'(STARVE_LIMIT);
    localparam logic [3:0]    ZERO_REG = 4'd15;

    logic [3:0]    mem_rd   [FIFO_DEPTH];
    logic [63:0]   mem_data [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          alu_stall_q, alu_stall_d;
    logic          rf_we_q, rf_we_d;
    logic [3:0]    rf_addr_q, rf_addr_d;
    logic [63:0]   rf_data_q, rf_data_d;
    logic          rf_src_lsu_q;
    logic [15:0]   pending_q, pending_d;
    logic          ready, fifo_empty, push, pop, alu_sel, sel;

    always_comb begin
        ready      = (count_q != FULL);
        fifo_empty = (count_q == '0);
        push       = bus.lsu_wb_valid && ready;
        alu_sel    = bus.alu_wb_valid && !alu_stall_q;
        pop        = !alu_sel && !fifo_empty;
        sel        = alu_sel || pop;
        rf_addr_d  = alu_sel ? bus.alu_wb_rd   : mem_rd[rd_ptr_q];
        rf_data_d  = alu_sel ? bus.alu_wb_data : mem_data[rd_ptr_q];
        rf_we_d    = sel && (rf_addr_d != ZERO_REG);

        count_d = count_q + CW'(push) - CW'(pop);

        starve_d = starve_q;
        if (fifo_empty || pop)
            starve_d = '0;
        else if (starve_q != SLIM)
            starve_d = starve_q + SW'(1);

        // Stall is registered, so it is decided from next-cycle occupancy and wait time
        alu_stall_d = (count_d == FULL) || (starve_d >= SLIM);

        // Clear lands on the RF commit edge; a same-edge issue to that register wins
        pending_d = pending_q;
        if (rf_we_q && rf_src_lsu_q)
            pending_d[rf_addr_q] = 1'b0;
        if (bus.lsu_issue_valid && (bus.lsu_issue_rd != ZERO_REG))
            pending_d[bus.lsu_issue_rd] = 1'b1;
        pending_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr_q]   <= bus.lsu_wb_rd;
            mem_data[wr_ptr_q] <= bus.lsu_wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            alu_stall_q  <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_addr_q    <= '0;
            rf_data_q    <= '0;
            rf_src_lsu_q <= 1'b0;
            pending_q    <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q      <= count_d;
            starve_q     <= starve_d;
            alu_stall_q  <= alu_stall_d;
            rf_we_q      <= rf_we_d;
            rf_src_lsu_q <= pop;
            if (sel) begin
                rf_addr_q <= rf_addr_d;
                rf_data_q <= rf_data_d;
            end
            pending_q    <= pending_d;
        end
    end

    assign bus.alu_stall    = alu_stall_q;
    assign bus.lsu_wb_ready = ready;
    assign bus.rf_we        = rf_we_q;
    assign bus.rf_rd_addr   = rf_addr_q;
    assign bus.rf_rd_data   = rf_data_q;
    assign bus.fifo_count   = count_q;
    assign bus.hz_busy      = pending_q[bus.hz_rs1_addr] | pending_q[bus.hz_rs2_addr]
                            | pending_q[bus.hz_rd_addr];
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single synchronous write port between two sources: the in-order ALU writeback and the out-of-order LSU load return.
- Buffers LSU returns in a small FIFO and tracks a per-register pending-load scoreboard for issue-stage hazard checks.
- Suppresses writes to r15, the zero register.
- Sits between the gpu_core writeback stage and the register file write port.

Parameters:
- FIFO_DEPTH, 4, LSU return buffer entries; power of 2, minimum 2.
- STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO head may wait before the ALU is stalled; minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- alu_wb_valid  in  1  ALU result valid; held by upstream while alu_stall=1
- alu_wb_rd  in  4  ALU destination register
- alu_wb_data  in  64  ALU result
- alu_stall  out  1  registered; ALU writeback blocked this cycle
- lsu_issue_valid  in  1  load issued; marks lsu_issue_rd pending
- lsu_issue_rd  in  4  load destination register
- lsu_wb_valid  in  1  load data returning
- lsu_wb_rd  in  4  load destination register
- lsu_wb_data  in  64  load data
- lsu_wb_ready  out  1  FIFO accepts (count < FIFO_DEPTH)
- rf_we  out  1  registered write enable to the register file
- rf_rd_addr  out  4  registered write address
- rf_rd_data  out  64  registered write data
- hz_rs1_addr  in  4  issue-stage source 1
- hz_rs2_addr  in  4  issue-stage source 2
- hz_rd_addr  in  4  issue-stage destination
- hz_busy  out  1  combinational; any hz_* register is pending
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
Reset (asynchronous, any time, including mid-operation):
- FIFO flushed; count=0; starve_cnt=0; pending=0.
- rf_we=0, rf_rd_addr=0, rf_rd_data=0, alu_stall=0.
- hz_busy=0, lsu_wb_ready=1.

FIFO:
- Push when lsu_wb_valid && lsu_wb_ready. No pass-through: a push is visible at the head the next cycle.
- lsu_wb_ready is low when full, so push and pop never both occur when full.
- Push and pop in the same cycle leave count unchanged.

Arbitration (combinational select in cycle N):
- ALU wins if alu_wb_valid && !alu_stall.
- Otherwise, if the FIFO is non-empty, the FIFO head is selected and popped.
- Otherwise nothing is selected.
- ALU results are never buffered. alu_stall=1 guarantees the FIFO pops that cycle.

Write latency:
- The selection in cycle N is registered; rf_* is valid during N+1, and the register file commits at the end of N+1.
- rf_we = selected && (sel_rd != 15). An r15 entry is consumed (popped or accepted) but never written.

Starvation:
- starve_cnt increments each cycle the FIFO is non-empty and not popped, saturating at STARVE_LIMIT.
- starve_cnt clears on a pop or when the FIFO is empty.
- alu_stall (registered) next = (count_next == FIFO_DEPTH) || (starve_next >= STARVE_LIMIT).

Scoreboard (16 bits):
- Set pending[lsu_issue_rd] on lsu_issue_valid, unless rd==15.
- Clear pending[rd] at the edge ending a cycle in which rf_we=1 and the registered source is the LSU. This is the same edge the register file commits, so a reader cannot see stale data.
- If a set and a clear hit the same register on the same edge, set wins.
- pending[15] is always 0.
- hz_busy = pending[hz_rs1_addr] | pending[hz_rs2_addr] | pending[hz_rd_addr], which also covers WAW.
- Issuing a load to an already-pending rd is a protocol violation; the bit stays set.
- ALU writes never touch the scoreboard.

Test Plan:
- ALU only: alu_wb_valid every cycle, rd=3..6, data=0xA0..0xA3 -> rf_we=1 one cycle later each cycle with matching addr/data; alu_stall stays 0.
- Load path: issue load rd=5 -> hz_busy=1 for hz_rs1_addr=5. Return data 0xDEADBEEF with ALU idle -> rf write r5 two cycles after return. hz_busy drops at that commit edge.
- Starvation: ALU valid continuously, one LSU return rd=7 -> FIFO waits 3 cycles, then alu_stall=1 for one cycle. r7 is written next, and ALU writes resume with no ALU result lost.
- Full FIFO: ALU saturated, 4 LSU returns -> lsu_wb_ready=0 and fifo_count=4; alu_stall=1 until a pop; no push accepted while full.
- r15: ALU rd=15 and LSU rd=15 (issue rd=15) -> rf_we never 1; pending[15] stays 0; FIFO entry consumed.
- Reset mid-op with 3 FIFO entries and pending={2,9} -> the cycle after rst deasserts: fifo_count=0, hz_busy=0, rf_we=0, alu_stall=0.
